// File: rtl/vga_pkg.sv
// Shared timing defaults, geometry struct and derivation helpers for the VGA
// timing generator.
package vga_pkg;

   localparam int DEF_H_SYNC  = 120;
   localparam int DEF_H_BACK  = 64;
   localparam int DEF_H_DISP  = 800;
   localparam int DEF_H_FRONT = 56;
   localparam int DEF_V_SYNC  = 6;
   localparam int DEF_V_BACK  = 23;
   localparam int DEF_V_DISP  = 600;
   localparam int DEF_V_FRONT = 37;

   localparam bit POL_LOW  = 1'b0;
   localparam bit POL_HIGH = 1'b1;

   typedef struct packed {
      int h_sync;
      int h_back;
      int h_disp;
      int h_front;
      int v_sync;
      int v_back;
      int v_disp;
      int v_front;
   } vga_timing_t;

   function automatic int vga_total(
      input int s,
      input int b,
      input int d,
      input int f
   );
      return s + b + d + f;
   endfunction

   // Bit width able to index 0..n-1, never narrower than one bit.
   function automatic int vga_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video-side bundle of the timing generator.
// pat_rgb exists only when VGA_PATTERN_EN is defined.
interface vga_timing_gen_if #(
   parameter int XW = 10,
   parameter int YW = 10
);

   logic          VGA_HS;
   logic          VGA_VS;
   logic          de;
   logic [XW-1:0] xpos;
   logic [YW-1:0] ypos;
   logic          frame_start;
   logic          line_req;
   logic [YW-1:0] line_req_row;
`ifdef VGA_PATTERN_EN
   logic [11:0]   pat_rgb;

   modport master (
      output VGA_HS, VGA_VS, de, xpos, ypos,
      output frame_start, line_req, line_req_row,
      output pat_rgb
   );
   modport slave (
      input VGA_HS, VGA_VS, de, xpos, ypos,
      input frame_start, line_req, line_req_row,
      input pat_rgb
   );
`else
   modport master (
      output VGA_HS, VGA_VS, de, xpos, ypos,
      output frame_start, line_req, line_req_row
   );
   modport slave (
      input VGA_HS, VGA_VS, de, xpos, ypos,
      input frame_start, line_req, line_req_row
   );
`endif

endinterface

// File: rtl/vga_axis_counter.sv
// Wrap counter for one scan axis: clr zeroes, adv steps, wrap flags the
// step out of the last position.
module vga_axis_counter #(
   parameter int TOTAL = 2,
   parameter int W     = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         adv,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(TOTAL - 1);

   logic [W-1:0] cnt_d;
   logic [W-1:0] cnt_q;

   assign wrap = adv && (cnt_q == LAST);
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (wrap)
         cnt_d = '0;
      else if (adv)
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/active-window generator with per-line prefetch.
// Define VGA_PATTERN_EN to add the colour-bar pat_rgb output.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_SYNC  = DEF_H_SYNC,
   parameter int H_BACK  = DEF_H_BACK,
   parameter int H_DISP  = DEF_H_DISP,
   parameter int H_FRONT = DEF_H_FRONT,
   parameter int V_SYNC  = DEF_V_SYNC,
   parameter int V_BACK  = DEF_V_BACK,
   parameter int V_DISP  = DEF_V_DISP,
   parameter int V_FRONT = DEF_V_FRONT,
   parameter bit HS_POL  = POL_LOW,
   parameter bit VS_POL  = POL_LOW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   vga_timing_gen_if.master vo
);

   localparam vga_timing_t TIM = '{
      h_sync: H_SYNC, h_back: H_BACK,
      h_disp: H_DISP, h_front: H_FRONT,
      v_sync: V_SYNC, v_back: V_BACK,
      v_disp: V_DISP, v_front: V_FRONT
   };

   localparam int H_TOTAL = vga_total(TIM.h_sync, TIM.h_back,
                                      TIM.h_disp, TIM.h_front);
   localparam int V_TOTAL = vga_total(TIM.v_sync, TIM.v_back,
                                      TIM.v_disp, TIM.v_front);
   localparam int H_START = TIM.h_sync + TIM.h_back;
   localparam int V_START = TIM.v_sync + TIM.v_back;
   localparam int HW = vga_width(H_TOTAL);
   localparam int VW = vga_width(V_TOTAL);
   localparam int XW = vga_width(H_DISP);
   localparam int YW = vga_width(V_DISP);

   localparam logic [HW-1:0] H_SYNC_C  = HW'(H_SYNC);
   localparam logic [HW-1:0] H_START_C = HW'(H_START);
   localparam logic [HW-1:0] H_END_C   = HW'(H_START + H_DISP);
   localparam logic [VW-1:0] V_SYNC_C  = VW'(V_SYNC);
   localparam logic [VW-1:0] V_START_C = VW'(V_START);
   localparam logic [VW-1:0] V_END_C   = VW'(V_START + V_DISP);

   if (H_SYNC == 0 || H_BACK == 0 || H_DISP == 0 || H_FRONT == 0 ||
       V_SYNC == 0 || V_BACK == 0 || V_DISP == 0 || V_FRONT == 0)
   begin : g_bad_geom
      $error("vga_timing_gen: zero-width timing parameter");
   end

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_wrap;
   logic          v_wrap;

   vga_axis_counter #(.TOTAL(H_TOTAL), .W(HW)) u_h_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (~en),
      .adv   (1'b1),
      .cnt   (h_cnt),
      .wrap  (h_wrap)
   );

   vga_axis_counter #(.TOTAL(V_TOTAL), .W(VW)) u_v_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (~en),
      .adv   (h_wrap),
      .cnt   (v_cnt),
      .wrap  (v_wrap)
   );

   logic          hs_d, hs_q;
   logic          vs_d, vs_q;
   logic          de_d, de_q;
   logic [XW-1:0] xpos_d, xpos_q;
   logic [YW-1:0] ypos_d, ypos_q;
   logic          fs_d, fs_q;
   logic          lreq_d, lreq_q;
   logic [YW-1:0] lrow_d, lrow_q;
   logic [VW-1:0] next_v;
   logic          h_act, v_act, next_act;

   // v_wrap is only meaningful at h_wrap, which is exactly when next_v is used.
   always_comb begin
      next_v   = v_wrap ? '0 : v_cnt + VW'(1);
      h_act    = (h_cnt >= H_START_C) && (h_cnt < H_END_C);
      v_act    = (v_cnt >= V_START_C) && (v_cnt < V_END_C);
      next_act = (next_v >= V_START_C) && (next_v < V_END_C);
      hs_d     = ~HS_POL;
      vs_d     = ~VS_POL;
      de_d     = 1'b0;
      xpos_d   = '0;
      ypos_d   = '0;
      fs_d     = 1'b0;
      lreq_d   = 1'b0;
      lrow_d   = '0;
      if (en) begin
         hs_d   = (h_cnt < H_SYNC_C) ? HS_POL : ~HS_POL;
         vs_d   = (v_cnt < V_SYNC_C) ? VS_POL : ~VS_POL;
         de_d   = h_act && v_act;
         fs_d   = (h_cnt == '0) && (v_cnt == '0);
         lreq_d = h_wrap && next_act;
         if (de_d) begin
            xpos_d = XW'(h_cnt - H_START_C);
            ypos_d = YW'(v_cnt - V_START_C);
         end
         if (lreq_d)
            lrow_d = YW'(next_v - V_START_C);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_q   <= ~HS_POL;
         vs_q   <= ~VS_POL;
         de_q   <= 1'b0;
         xpos_q <= '0;
         ypos_q <= '0;
         fs_q   <= 1'b0;
         lreq_q <= 1'b0;
         lrow_q <= '0;
      end else begin
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         de_q   <= de_d;
         xpos_q <= xpos_d;
         ypos_q <= ypos_d;
         fs_q   <= fs_d;
         lreq_q <= lreq_d;
         lrow_q <= lrow_d;
      end
   end

   assign vo.VGA_HS       = hs_q;
   assign vo.VGA_VS       = vs_q;
   assign vo.de           = de_q;
   assign vo.xpos         = xpos_q;
   assign vo.ypos         = ypos_q;
   assign vo.frame_start  = fs_q;
   assign vo.line_req     = lreq_q;
   assign vo.line_req_row = lrow_q;

`ifdef VGA_PATTERN_EN
   localparam int BAR_W = H_DISP / 8;

   logic [2:0]  bar;
   logic [11:0] pat_d, pat_q;

   // Bar index derived from the same column that feeds xpos_q, so it aligns.
   always_comb begin
      bar = '0;
      for (int i = 1; i < 8; i++) begin
         if (int'(xpos_d) >= i * BAR_W)
            bar = 3'(i);
      end
      unique case (bar)
         3'd0:    pat_d = 12'hFFF;
         3'd1:    pat_d = 12'hFF0;
         3'd2:    pat_d = 12'h0FF;
         3'd3:    pat_d = 12'h0F0;
         3'd4:    pat_d = 12'hF0F;
         3'd5:    pat_d = 12'hF00;
         3'd6:    pat_d = 12'h00F;
         default: pat_d = 12'h000;
      endcase
      if (!de_d)
         pat_d = 12'h000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pat_q <= '0;
      else
         pat_q <= pat_d;
   end

   assign vo.pat_rgb = pat_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a small 14x7 geometry with
// high-active HS.
module tb_vga_timing_gen;

   localparam int NREC = 196;

   logic clk;
   logic rst_n;
   logic en;

   int total;
   int bad;

   vga_timing_gen_if #(.XW(3), .YW(2)) vif ();

   vga_timing_gen #(
      .H_SYNC (2), .H_BACK (2), .H_DISP (8), .H_FRONT (2),
      .V_SYNC (1), .V_BACK (1), .V_DISP (4), .V_FRONT (1),
      .HS_POL (1'b1), .VS_POL (1'b0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .vo    (vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       hs;
      logic       vs;
      logic       de;
      logic [2:0] x;
      logic [1:0] y;
      logic       fs;
      logic       lr;
      logic [1:0] row;
      logic [11:0] pat;
   } rec_t;

   typedef struct {
      int   t;
      logic hs;
      logic vs;
      logic de;
      int   x;
      int   y;
      logic fs;
      logic lr;
      int   row;
   } vec_t;

   rec_t rec [NREC];
   vec_t vt [21];

   task automatic chk(
      input string       nm,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic rec_t sample();
      rec_t r;
      r.hs  = vif.VGA_HS;
      r.vs  = vif.VGA_VS;
      r.de  = vif.de;
      r.x   = vif.xpos;
      r.y   = vif.ypos;
      r.fs  = vif.frame_start;
      r.lr  = vif.line_req;
      r.row = vif.line_req_row;
`ifdef VGA_PATTERN_EN
      r.pat = vif.pat_rgb;
`else
      r.pat = 12'h000;
`endif
      return r;
   endfunction

   initial begin
      int   n_de, n_lr, n_hs, n_vs, n_fs;
      int   rows [$];
      int   flen;
      bit   seen;
      rec_t r;

      total = 0;
      bad   = 0;

      //        t    hs    vs    de    x  y  fs    lr    row
      vt[0]  = '{0,  1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 0};
      vt[1]  = '{1,  1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0};
      vt[2]  = '{2,  1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0};
      vt[3]  = '{13, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0};
      vt[4]  = '{14, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0};
      vt[5]  = '{27, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 0};
      vt[6]  = '{28, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0};
      vt[7]  = '{31, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0};
      vt[8]  = '{32, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 0};
      vt[9]  = '{39, 1'b0, 1'b1, 1'b1, 7, 0, 1'b0, 1'b0, 0};
      vt[10] = '{40, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0};
      vt[11] = '{41, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1};
      vt[12] = '{46, 1'b0, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 0};
      vt[13] = '{55, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 2};
      vt[14] = '{69, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 3};
      vt[15] = '{81, 1'b0, 1'b1, 1'b1, 7, 3, 1'b0, 1'b0, 0};
      vt[16] = '{83, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0};
      vt[17] = '{88, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0};
      vt[18] = '{97, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0};
      vt[19] = '{98, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 0};
      vt[20] = '{130, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 0};

      rst_n = 1'b0;
      en    = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_hs", vif.VGA_HS, 0);
      chk("rst_vs", vif.VGA_VS, 1);
      chk("rst_de", vif.de, 0);
      chk("rst_x", vif.xpos, 0);
      chk("rst_y", vif.ypos, 0);
      chk("rst_fs", vif.frame_start, 0);
      chk("rst_lr", vif.line_req, 0);
      chk("rst_row", vif.line_req_row, 0);
      rst_n = 1'b1;

      for (int t = 0; t < NREC; t++) begin
         @(posedge clk);
         #1;
         rec[t] = sample();
      end

      for (int i = 0; i < 21; i++) begin
         r = rec[vt[i].t];
         chk($sformatf("t%0d_hs", vt[i].t), r.hs, vt[i].hs);
         chk($sformatf("t%0d_vs", vt[i].t), r.vs, vt[i].vs);
         chk($sformatf("t%0d_de", vt[i].t), r.de, vt[i].de);
         chk($sformatf("t%0d_x", vt[i].t), r.x, vt[i].x);
         chk($sformatf("t%0d_y", vt[i].t), r.y, vt[i].y);
         chk($sformatf("t%0d_fs", vt[i].t), r.fs, vt[i].fs);
         chk($sformatf("t%0d_lr", vt[i].t), r.lr, vt[i].lr);
         chk($sformatf("t%0d_row", vt[i].t), r.row, vt[i].row);
      end

      n_de = 0; n_lr = 0; n_hs = 0; n_vs = 0; n_fs = 0;
      for (int t = 0; t < 98; t++) begin
         if (rec[t].de === 1'b1) n_de++;
         if (rec[t].hs === 1'b1) n_hs++;
         if (rec[t].vs === 1'b0) n_vs++;
         if (rec[t].fs === 1'b1) n_fs++;
         if (rec[t].lr === 1'b1) begin
            n_lr++;
            rows.push_back(int'(rec[t].row));
         end
      end
      chk("frame_de_cnt", n_de, 32);
      chk("frame_lr_cnt", n_lr, 4);
      chk("frame_hs_cnt", n_hs, 14);
      chk("frame_vs_cnt", n_vs, 14);
      chk("frame_fs_cnt", n_fs, 1);
      for (int i = 0; i < rows.size(); i++)
         chk($sformatf("lr_row_seq%0d", i), rows[i], i);

`ifdef VGA_PATTERN_EN
      chk("pat_t0", rec[0].pat, 12'h000);
      chk("pat_x0", rec[32].pat, 12'hFFF);
      chk("pat_x1", rec[33].pat, 12'hFF0);
      chk("pat_x2", rec[34].pat, 12'h0FF);
      chk("pat_x3", rec[35].pat, 12'h0F0);
      chk("pat_x6", rec[38].pat, 12'h00F);
      chk("pat_x7", rec[39].pat, 12'h000);
      chk("pat_fp", rec[40].pat, 12'h000);
`endif

      // Advance into the active area of frame 2 and abort the frame there.
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         #1;
      end
      chk("pre_drop_de", vif.de, 1);
      chk("pre_drop_x", vif.xpos, 3);
      chk("pre_drop_y", vif.ypos, 1);
      en = 1'b0;
      @(posedge clk);
      #1;
      chk("drop_hs", vif.VGA_HS, 0);
      chk("drop_vs", vif.VGA_VS, 1);
      chk("drop_de", vif.de, 0);
      chk("drop_x", vif.xpos, 0);
      chk("drop_fs", vif.frame_start, 0);
      chk("drop_lr", vif.line_req, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("idle_fs", vif.frame_start, 0);
      chk("idle_hs", vif.VGA_HS, 0);

      en = 1'b1;
      @(posedge clk);
      #1;
      chk("rerun_fs", vif.frame_start, 1);
      chk("rerun_hs", vif.VGA_HS, 1);
      chk("rerun_vs", vif.VGA_VS, 0);
      chk("rerun_de", vif.de, 0);

      seen = 1'b0;
      flen = 0;
      for (int i = 1; i <= 200 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (vif.frame_start === 1'b1) begin
            seen = 1'b1;
            flen = i;
         end
      end
      chk("rerun_next_fs_seen", seen, 1);
      chk("rerun_frame_len", flen, 98);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
